// File: rtl/pk_extract.sv
// pk_extract: unload stage of the GF(2^m) systemizer.
// Reads the non-identity column blocks (L/N .. K/N-1) of the systemized
// L x K matrix from the phase memory and streams them row-major over a
// valid/ready interface. A two-credit scheme keeps the 2-entry output FIFO
// from ever overflowing, and a one-cycle done pulse follows the final word.
module pk_extract #(
  parameter int N = 4,
  parameter int M = 1,
  parameter int L = 8,
  parameter int K = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [$clog2(L*K/N)-1:0] rd_addr,
  input  logic [N*M-1:0]           rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*M-1:0]           out_data,
  output logic                     out_last
);
  localparam int AW = $clog2(L*K/N);
  localparam int DW = N*M;
  localparam int W  = L*(K-L)/N;
  localparam int CW = $clog2(W+1);
  localparam int BW = $clog2(K/N);
  localparam int RW = $clog2(L+1);

  localparam logic [BW-1:0] FIRST_BLK = BW'(L/N);
  localparam logic [BW-1:0] LAST_BLK  = BW'(K/N-1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(L-1);
  localparam logic [CW-1:0] W_CNT     = CW'(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [BW-1:0]   blk;
  logic [RW-1:0]   row;
  logic [CW-1:0]   issued;
  logic [1:0]      credit;
  logic            rd_pend;
  logic            rd_pend_last;
  logic [DW-1:0]   head_data, tail_data;
  logic            head_last, tail_last;
  logic [1:0]      fifo_count;
  logic            pop;
  logic            final_read;
  logic            done_set;
  logic            launch;

  // The address is derived from the counters; they freeze after the final
  // read, so rd_addr simply holds its last value while rd_en is low.
  assign rd_addr    = AW'(blk) * AW'(L) + AW'(row);
  assign final_read = (row == LAST_ROW) && (blk == LAST_BLK);
  assign out_valid  = (fifo_count != 2'd0);
  assign out_data   = head_data;
  assign out_last   = head_last;
  assign pop        = out_valid && out_ready;
  assign busy       = (state != IDLE);
  assign launch     = (state == IDLE) && start;

  // Next-state and read strobe; a handshake in the same cycle frees a slot,
  // which lets reads continue at full rate even with zero stored credit.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    done_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        rd_en = (issued < W_CNT) && ((credit != 2'd0) || pop);
        if (rd_en && final_read) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_next = IDLE;
          done_set   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the registered completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_set;
    end
  end

  // Block/row walk, issued-word count and read credits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk    <= '0;
      row    <= '0;
      issued <= '0;
      credit <= 2'd2;
    end else if (launch) begin
      blk    <= FIRST_BLK;
      row    <= '0;
      issued <= '0;
      credit <= 2'd2;
    end else begin
      if (rd_en) begin
        issued <= issued + CW'(1);
        if (!final_read) begin
          if (blk == LAST_BLK) begin
            blk <= FIRST_BLK;
            row <= row + RW'(1);
          end else begin
            blk <= blk + BW'(1);
          end
        end
      end
      if (rd_en && !pop) credit <= credit - 2'd1;
      else if (!rd_en && pop) credit <= credit + 2'd1;
    end
  end

  // Tracks the read whose data arrives on rd_data in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && final_read;
    end
  end

  // Two-entry output FIFO; the head entry drives the output port directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data  <= '0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_last  <= 1'b0;
      fifo_count <= 2'd0;
    end else if (rd_pend && pop) begin
      if (fifo_count == 2'd2) begin
        head_data <= tail_data;
        head_last <= tail_last;
        tail_data <= rd_data;
        tail_last <= rd_pend_last;
      end else begin
        head_data <= rd_data;
        head_last <= rd_pend_last;
      end
    end else if (rd_pend) begin
      if (fifo_count == 2'd0) begin
        head_data <= rd_data;
        head_last <= rd_pend_last;
      end else begin
        tail_data <= rd_data;
        tail_last <= rd_pend_last;
      end
      fifo_count <= fifo_count + 2'd1;
    end else if (pop) begin
      head_data  <= tail_data;
      head_last  <= tail_last;
      fifo_count <= fifo_count - 2'd1;
    end
  end

endmodule

// File: tb/tb_pk_extract.sv
// tb_pk_extract: randomized-backpressure bench for pk_extract with a
// queue-based model of the unload order, plus a small second instance.
module tb_pk_extract;
  localparam int N  = 4;
  localparam int M  = 1;
  localparam int L  = 8;
  localparam int K  = 16;
  localparam int W  = L*(K-L)/N;
  localparam int AW = $clog2(L*K/N);
  localparam int DW = N*M;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, rd_en, out_valid, out_ready, out_last;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;

  logic          s_start, s_busy, s_done, s_rd_en, s_out_valid, s_out_ready, s_out_last;
  logic [3:0]    s_rd_addr;
  logic [1:0]    s_rd_data, s_out_data;

  int            n_pass = 0;
  int            n_total = 0;
  int            cyc = 0;
  int            rmode = 0;
  int            pidx = 0;
  logic [3:0]    pat = 4'b1001;
  logic [DW-1:0] key = '0;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] addr_log[$];
  logic [DW-1:0] data_log[$];
  logic          exp_busy = 1'b0;
  logic          exp_done = 1'b0;
  logic          stall_hold = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic          hs_now, last_hs, nb, nd;
  int            issued = 0;
  int            popped = 0;
  int            done_count = 0;
  int            done_cyc = 0;
  int            start_cyc = 0;
  int            first_valid_cyc = -1;
  int            d0 = 0;
  int unsigned   seed_dummy;

  pk_extract #(.N(N), .M(M), .L(L), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  pk_extract #(.N(2), .M(1), .L(4), .K(8)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_last(s_out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [DW-1:0] mem_word(input int a);
    return DW'(a) ^ key;
  endfunction

  // Phase memory models: registered read, data one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem_word(int'(rd_addr));
    if (s_rd_en) s_rd_data <= s_rd_addr[1:0];
  end

  // Consumer backpressure: always ready, 1,0,0,1 pattern, random, or stalled.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = pat[pidx];
        pidx = (pidx + 1) % 4;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Compare process: checks every cycle against the queue model, then
  // advances the model for what the next clock edge will do.
  always @(negedge clk) begin
    if (!rst) begin
      check_output("busy", busy, exp_busy);
      check_output("done", done, exp_done);
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (!exp_busy) check_output("rd_idle", rd_en, 1'b0);
      if (rd_en) begin
        issued++;
        addr_log.push_back(rd_addr);
        if (exp_addr.size() == 0) check_output("rd_extra", issued, W);
        else check_output("rd_addr", rd_addr, exp_addr.pop_front());
      end
      if (stall_hold) begin
        check_output("stall_valid", out_valid, 1'b1);
        check_output("stall_data", out_data, stall_data);
      end
      hs_now  = out_valid && out_ready;
      last_hs = 1'b0;
      if (hs_now) begin
        popped++;
        data_log.push_back(out_data);
        if (exp_data.size() == 0) check_output("out_extra", popped, W);
        else begin
          check_output("out_data", out_data, exp_data.pop_front());
          check_output("out_last", out_last, exp_data.size() == 0);
          last_hs = (exp_data.size() == 0);
        end
      end
      check_output("outstanding", (issued - popped) <= 2, 1'b1);
      if (exp_busy && out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      stall_hold = out_valid && !out_ready;
      stall_data = out_data;
      nb = exp_busy;
      nd = 1'b0;
      if (start && !exp_busy) begin
        exp_addr.delete();
        exp_data.delete();
        addr_log.delete();
        data_log.delete();
        for (int r = 0; r < L; r++)
          for (int b = L/N; b < K/N; b++) begin
            exp_addr.push_back(AW'(b*L + r));
            exp_data.push_back(mem_word(b*L + r));
          end
        nb = 1'b1;
        start_cyc = cyc;
        issued = 0;
        popped = 0;
        first_valid_cyc = -1;
      end
      if (last_hs) begin
        nb = 1'b0;
        nd = 1'b1;
      end
      exp_busy = nb;
      exp_done = nd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_unload();
    d0 = done_count;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_unload();
    int guard = 0;
    while (done_count == d0 && guard < 300) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    check_output("single_done", done_count - d0, 1);
    check_output("addr_left", exp_addr.size(), 0);
    check_output("data_left", exp_data.size(), 0);
  endtask

  task automatic wait_popped(input int n);
    int guard = 0;
    while (popped < n && guard < 200) begin
      tick();
      guard++;
    end
    check_output("reach_word", popped >= n, 1'b1);
  endtask

  task automatic check_reset_outputs();
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_done", done, 1'b0);
    check_output("rst_rd_en", rd_en, 1'b0);
    check_output("rst_rd_addr", rd_addr, 0);
    check_output("rst_valid", out_valid, 1'b0);
    check_output("rst_data", out_data, 0);
    check_output("rst_last", out_last, 1'b0);
  endtask

  // Small instance (N=2, L=4, K=8): full sequence, last tag and latency.
  task automatic run_small();
    logic [3:0] a_q[$];
    logic [1:0] d_q[$];
    logic       l_q[$];
    int         sc, dc, guard;
    bit         got;
    logic [3:0] ea;
    s_start = 1'b1;
    @(negedge clk);
    sc = cyc;
    @(posedge clk);
    #1 s_start = 1'b0;
    guard = 0;
    got = 1'b0;
    dc = 0;
    while (!got && guard < 60) begin
      @(negedge clk);
      guard++;
      if (s_rd_en) a_q.push_back(s_rd_addr);
      if (s_out_valid && s_out_ready) begin
        d_q.push_back(s_out_data);
        l_q.push_back(s_out_last);
      end
      if (s_done) begin
        got = 1'b1;
        dc = cyc;
      end
    end
    check_output("s_done_seen", got, 1'b1);
    check_output("s_latency", dc - sc, 11);
    check_output("s_reads", a_q.size(), 8);
    check_output("s_words", d_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      ea = 4'((2 + (i % 2)) * 4 + i / 2);
      if (i < a_q.size()) check_output("s_rd_addr", a_q[i], ea);
      if (i < d_q.size()) begin
        check_output("s_data", d_q[i], ea[1:0]);
        check_output("s_last", l_q[i], i == 7);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    s_start = 1'b0;
    s_out_ready = 1'b1;
    out_ready = 1'b1;
    rmode = 0;
    key = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Plain unload, memory word[a] = a, consumer always ready.
    start_unload();
    finish_unload();
    check_output("lat_done", done_cyc - start_cyc, 19);
    check_output("lat_valid", first_valid_cyc - start_cyc, 3);
    check_output("word_count", data_log.size(), 16);
    if (data_log.size() == 16) begin
      check_output("first_word", data_log[0], 4'd0);
      check_output("second_word", data_log[1], 4'd8);
      check_output("last_word", data_log[15], 4'd15);
    end

    // 1,0,0,1 ready pattern with scrambled memory contents.
    key = DW'($urandom_range(0, 15));
    rmode = 1;
    start_unload();
    finish_unload();

    // Random ready from seed 0x5A.
    seed_dummy = $urandom(32'h5A);
    key = DW'($urandom_range(0, 15));
    rmode = 2;
    start_unload();
    finish_unload();

    // Consumer stalled for 10 cycles right after start.
    key = '0;
    rmode = 3;
    start_unload();
    repeat (10) tick();
    check_output("stall_reads", issued, 2);
    check_output("stall_out_valid", out_valid, 1'b1);
    check_output("stall_out_data", out_data, mem_word(16));
    if (addr_log.size() >= 2) begin
      check_output("stall_addr0", addr_log[0], 16);
      check_output("stall_addr1", addr_log[1], 24);
    end
    rmode = 0;
    finish_unload();

    // Extra start while busy at word 5 must be ignored.
    rmode = 1;
    start_unload();
    wait_popped(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_unload();
    check_output("dup_start_words", data_log.size(), 16);

    // Asynchronous reset mid-unload at word 7, then a fresh unload.
    rmode = 0;
    start_unload();
    wait_popped(7);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    exp_addr.delete();
    exp_data.delete();
    exp_busy = 1'b0;
    exp_done = 1'b0;
    stall_hold = 1'b0;
    issued = 0;
    popped = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    start_unload();
    finish_unload();
    if (addr_log.size() > 0) check_output("post_rst_addr", addr_log[0], 16);
    check_output("post_rst_words", data_log.size(), 16);

    run_small();

    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
